// File: rtl/secuenciador_alu.sv
// secuenciador_alu
// ----------------
// Sequencing controller for the 4-bit ALU operator. Holds a 4 x 4-bit
// register file, accepts 8-bit commands, issues operands to the ALU, holds
// them for ALU_LAT cycles, captures the ALU result, optionally writes it
// back and reports it on a one-cycle strobe.
//
// Ports
//   clk, rst            clock (rising edge), synchronous active-high reset
//   cmd_valid/ready     command handshake
//   cmd_instr[7:0]      [7:5] opcode, [4] writeback, [3:2] rA, [1:0] rB
//   ld_en/addr/data     register-file load port, usable in any state
//   alu_instr/a/b       operands driven to the ALU (held while it computes)
//   alu_result          ALU output (dato_mux)
//   res_valid/data/dest one-cycle result strobe, value, destination (rA)
//   err_op              one-cycle strobe for opcodes 6/7
//   busy                high whenever the controller is not IDLE
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. The source holds cmd_valid and cmd_instr stable
// until that edge; cmd_valid while cmd_ready is low is ignored. cmd_ready is
// high in IDLE and in DONE, so a new command can overlap the writeback edge
// of the previous one and still reads the pre-write register values.
module secuenciador_alu #(
    parameter int ALU_LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_instr,
    input  logic       ld_en,
    input  logic [1:0] ld_addr,
    input  logic [3:0] ld_data,
    output logic [7:0] alu_instr,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [3:0] alu_result,
    output logic       res_valid,
    output logic [3:0] res_data,
    output logic [1:0] res_dest,
    output logic       err_op,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(ALU_LAT - 1);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [3:0] rf [4];

    logic       cmd_ready_n;
    logic [7:0] alu_instr_n;
    logic [3:0] alu_a_n, alu_b_n;
    logic       res_valid_n;
    logic [3:0] res_data_n;
    logic [1:0] res_dest_n;
    logic       err_op_n;
    logic       busy_n;
    logic       accept;
    logic       wb_en;

    // Next-state and next-output logic. alu_instr doubles as the latched
    // instruction: its rA/writeback fields drive the DONE-cycle writeback.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        cmd_ready_n = cmd_ready;
        alu_instr_n = alu_instr;
        alu_a_n     = alu_a;
        alu_b_n     = alu_b;
        res_valid_n = 1'b0;
        res_data_n  = res_data;
        res_dest_n  = res_dest;
        err_op_n    = 1'b0;
        wb_en       = 1'b0;
        accept      = cmd_valid && cmd_ready;

        case (state)
            IDLE: begin
                cmd_ready_n = 1'b1;
            end
            EXEC: begin
                cnt_n = cnt + 4'd1;
                if (cnt == LAST_CNT) begin
                    state_n     = DONE;
                    cmd_ready_n = 1'b1;
                end
            end
            DONE: begin
                res_valid_n = 1'b1;
                res_data_n  = alu_result;
                res_dest_n  = alu_instr[3:2];
                wb_en       = alu_instr[4];
                state_n     = IDLE;
                cmd_ready_n = 1'b1;
            end
            ERR: begin
                state_n     = IDLE;
                cmd_ready_n = 1'b1;
            end
            default: begin
                state_n     = IDLE;
                cmd_ready_n = 1'b1;
            end
        endcase

        // Operands come straight from the register array, i.e. the values
        // before any writeback or load landing on this same edge.
        if (accept) begin
            cmd_ready_n = 1'b0;
            if (cmd_instr[7:5] <= 3'd5) begin
                alu_instr_n = cmd_instr;
                alu_a_n     = rf[cmd_instr[3:2]];
                alu_b_n     = rf[cmd_instr[1:0]];
                cnt_n       = 4'd0;
                state_n     = EXEC;
            end else begin
                // Opcodes 6/7 have no ALU result path: flag and drop.
                err_op_n = 1'b1;
                state_n  = ERR;
            end
        end

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            cmd_ready <= 1'b1;
            alu_instr <= 8'h00;
            alu_a     <= 4'd0;
            alu_b     <= 4'd0;
            res_valid <= 1'b0;
            res_data  <= 4'd0;
            res_dest  <= 2'd0;
            err_op    <= 1'b0;
            busy      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                rf[i] <= 4'd0;
            end
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cmd_ready <= cmd_ready_n;
            alu_instr <= alu_instr_n;
            alu_a     <= alu_a_n;
            alu_b     <= alu_b_n;
            res_valid <= res_valid_n;
            res_data  <= res_data_n;
            res_dest  <= res_dest_n;
            err_op    <= err_op_n;
            busy      <= busy_n;
            if (ld_en) begin
                rf[ld_addr] <= ld_data;
            end
            // Listed after the load so a writeback to the same address wins.
            if (wb_en) begin
                rf[alu_instr[3:2]] <= alu_result;
            end
        end
    end

endmodule
